cpu_clock_controller: RTL and testbench

CPU_CLOCK_CONTROLLER -- requirements
Module: cpu_clock_controller

---
 rtl/cpu_clock_controller.sv | 171 +++++++++++++++++
 tb/tb_cpu_clock_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - run/step/halt clock-enable controller for a single-domain CPU
//
// Optional feature: define CPU_CLOCK_CYCLE_COUNTER_EN to build the cycle counter.
//
// Ports:
//   clock_100mhz     in   1   single clock, all logic on rising edge
//   reset            in   1   synchronous, active-high
//   rate_select      in   5   run-mode enable period = 2^rate_select cycles
//   run_button       in   1   raw asynchronous button, press toggles run/pause
//   step_button      in   1   raw asynchronous button, press issues one CPU cycle
//   halt_request     in   1   level from CPU asking to stop
//   cpu_clock_enable out  1   registered one-cycle qualifier for the CPU
//   controller_state out  2   00 PAUSED, 01 RUNNING, 10 STEP, 11 HALTED
//   cycle_count      out  32  enable pulses issued (constant 0 without the counter)

module cpu_clock_controller #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clock_100mhz,
  input  logic        reset,
  input  logic [4:0]  rate_select,
  input  logic        run_button,
  input  logic        step_button,
  input  logic        halt_request,
  output logic        cpu_clock_enable,
  output logic [1:0]  controller_state,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'b00,
    ST_RUNNING = 2'b01,
    ST_STEP    = 2'b10,
    ST_HALTED  = 2'b11
  } state_t;

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1: the sample that
  // would make it DEBOUNCE_CYCLES flips the level and clears it instead.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 is the run button, bit 1 the step button.
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      deb;
  logic [1:0]      deb_d;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      press;
  logic            run_press;
  logic            step_press;

  assign raw = {step_button, run_button};

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        // Any sample agreeing with the current level breaks the run.
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign press      = deb & ~deb_d;
  assign run_press  = press[0];
  assign step_press = press[1];

  state_t      state;
  state_t      state_next;
  logic        en_q;
  logic        en_next;
  logic [31:0] presc;
  logic [31:0] presc_next;
  logic [31:0] presc_limit;
  logic        tick;

  // Compare with >= so that lowering rate_select below the current count
  // ticks immediately rather than waiting for a 32-bit wrap.
  assign presc_limit = (32'd1 << rate_select) - 32'd1;
  assign tick        = (presc >= presc_limit);

  always_comb begin
    state_next = state;
    en_next    = 1'b0;
    presc_next = '0;   // anything other than staying in RUNNING clears it
    unique case (state)
      ST_PAUSED: begin
        if (run_press) begin
          state_next = ST_RUNNING;
        end else if (step_press) begin
          state_next = ST_STEP;
          en_next    = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (halt_request) begin
          state_next = ST_HALTED;
        end else if (run_press) begin
          state_next = ST_PAUSED;
        end else begin
          en_next    = tick;
          presc_next = tick ? '0 : presc + 32'd1;
        end
      end
      ST_STEP: begin
        state_next = ST_PAUSED;
      end
      ST_HALTED: begin
        if (run_press) begin
          state_next = ST_PAUSED;
        end else if (step_press) begin
          state_next = ST_STEP;
          en_next    = 1'b1;
        end
      end
      default: begin
        state_next = ST_PAUSED;
      end
    endcase
  end

  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      state <= ST_PAUSED;
      en_q  <= 1'b0;
      presc <= '0;
    end else begin
      state <= state_next;
      en_q  <= en_next;
      presc <= presc_next;
    end
  end

  assign cpu_clock_enable = en_q;
  assign controller_state = state;

`ifdef CPU_CLOCK_CYCLE_COUNTER_EN
  logic [31:0] cycle_count_q;

  // Counted alongside the enable register so the count includes the
  // pulse currently visible on cpu_clock_enable.
  always_ff @(posedge clock_100mhz) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else if (en_next) begin
      cycle_count_q <= cycle_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - self-checking bench for cpu_clock_controller

module tb_cpu_clock_controller;

  localparam int D = 4;
`ifdef CPU_CLOCK_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rate_select = '0;
  logic        run_button = 1'b0;
  logic        step_button = 1'b0;
  logic        halt_request = 1'b0;
  logic        cpu_clock_enable;
  logic [1:0]  controller_state;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  cpu_clock_controller #(.DEBOUNCE_CYCLES(D)) dut (
    .clock_100mhz     (clk),
    .reset            (reset),
    .rate_select      (rate_select),
    .run_button       (run_button),
    .step_button      (step_button),
    .halt_request     (halt_request),
    .cpu_clock_enable (cpu_clock_enable),
    .controller_state (controller_state),
    .cycle_count      (cycle_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buttons seen two cycles late, level accepted once the
  // latest run of equal samples reaches D, press = level rose last cycle.
  // Running mode counts elapsed cycles and fires once 2^rate_select elapsed.
  int          m_state;
  bit          m_en;
  logic [31:0] m_cnt;
  longint      m_el;
  bit          ms1 [2];
  bit          ms2 [2];
  bit          mrv [2];
  int          mrl [2];
  bit          mdeb [2];
  bit          mpend [2];
  bit          mraw [2];
  bit          mrp, msp, msamp, mold;

  task automatic model_step();
    mraw[0] = run_button;
    mraw[1] = step_button;
    if (reset) begin
      m_state = 0; m_en = 0; m_cnt = 0; m_el = 0;
      for (int b = 0; b < 2; b++) begin
        ms1[b] = 0; ms2[b] = 0; mrv[b] = 0; mrl[b] = 0; mdeb[b] = 0; mpend[b] = 0;
      end
    end else begin
      mrp = mpend[0];
      msp = mpend[1];
      m_en = 0;
      case (m_state)
        0: if (mrp) begin m_state = 1; m_el = 0; end
           else if (msp) begin m_state = 2; m_en = 1; end
        1: if (halt_request) m_state = 3;
           else if (mrp) m_state = 0;
           else begin
             m_el++;
             if (m_el >= (64'd1 << rate_select)) begin m_en = 1; m_el = 0; end
           end
        2: m_state = 0;
        default: if (mrp) m_state = 0;
                 else if (msp) begin m_state = 2; m_en = 1; end
      endcase
      if (CNT_EN && m_en) m_cnt = m_cnt + 32'd1;
      for (int b = 0; b < 2; b++) begin
        msamp = ms2[b];
        ms2[b] = ms1[b];
        ms1[b] = mraw[b];
        if (msamp == mrv[b]) mrl[b] = (mrl[b] < 1000) ? mrl[b] + 1 : mrl[b];
        else begin mrv[b] = msamp; mrl[b] = 1; end
        mold = mdeb[b];
        if (mrl[b] >= D) mdeb[b] = mrv[b];
        mpend[b] = mdeb[b] & ~mold;
      end
    end
  endtask

  bit mchk = 0;

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mchk) begin
      check("model_state", 32'(controller_state), 32'(m_state));
      check("model_enable", 32'(cpu_clock_enable), 32'(m_en));
      check("model_count", cycle_count, m_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; run_button = 0; step_button = 0; halt_request = 0;
    cyc(2);
    reset = 0;
  endtask

  task automatic press(input bit which, input logic [1:0] exp, input string nm);
    if (which) step_button = 1; else run_button = 1;
    cyc(7);
    check(nm, 32'(controller_state), 32'(exp));
    run_button = 0;
    step_button = 0;
  endtask

  typedef struct {
    logic [4:0] rs;
    int         cycles;
    int         exp_en;
  } vec_t;

  vec_t vecs [5];
  int   sum, first, hold_r, hold_s;

  initial begin
    vecs[0] = '{rs: 5'd0, cycles: 10, exp_en: 10};
    vecs[1] = '{rs: 5'd1, cycles: 10, exp_en: 5};
    vecs[2] = '{rs: 5'd2, cycles: 12, exp_en: 3};
    vecs[3] = '{rs: 5'd3, cycles: 20, exp_en: 2};
    vecs[4] = '{rs: 5'd4, cycles: 33, exp_en: 2};

    cyc(2);
    reset = 0;
    mchk = 1;
    check("reset_state", 32'(controller_state), 32'd0);
    check("reset_enable", 32'(cpu_clock_enable), 32'd0);
    check("reset_count", cycle_count, 32'd0);

    // Run press then count enables over a fixed window per rate.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      rate_select = vecs[i].rs;
      run_button = 1;
      cyc(6);
      check("tbl_before_run", 32'(controller_state), 32'd0);
      cyc(1);
      check("tbl_running", 32'(controller_state), 32'd1);
      run_button = 0;
      sum = 0; first = 0;
      for (int k = 1; k <= vecs[i].cycles; k++) begin
        cyc(1);
        if (cpu_clock_enable) begin
          sum++;
          if (first == 0) first = k;
        end
      end
      check("tbl_enables", 32'(sum), 32'(vecs[i].exp_en));
      check("tbl_first_enable", 32'(first), 32'd1 << vecs[i].rs);
      check("tbl_count", cycle_count, CNT_EN ? 32'(vecs[i].exp_en) : 32'd0);
    end

    // Held step button: one STEP cycle, one enable.
    do_reset();
    step_button = 1;
    cyc(6);
    check("step_before", 32'(controller_state), 32'd0);
    cyc(1);
    check("step_state", 32'(controller_state), 32'd2);
    check("step_enable", 32'(cpu_clock_enable), 32'd1);
    cyc(1);
    check("step_back_paused", 32'(controller_state), 32'd0);
    sum = 0;
    repeat (12) begin cyc(1); sum += int'(cpu_clock_enable); end
    check("step_held_no_more", 32'(sum), 32'd0);
    step_button = 0;
    cyc(10);
    check("step_count", cycle_count, CNT_EN ? 32'd1 : 32'd0);

    // Halt from RUNNING, step past the halt, leave HALTED with run.
    do_reset();
    rate_select = 0;
    press(0, 2'd1, "halt_run_entry");
    cyc(3);
    check("halt_running_enable", 32'(cpu_clock_enable), 32'd1);
    halt_request = 1;
    cyc(1);
    check("halt_state", 32'(controller_state), 32'd3);
    check("halt_enable", 32'(cpu_clock_enable), 32'd0);
    sum = 0;
    repeat (5) begin cyc(1); sum += int'(cpu_clock_enable); end
    check("halted_no_enable", 32'(sum), 32'd0);
    press(1, 2'd2, "halt_step_state");
    check("halt_step_enable", 32'(cpu_clock_enable), 32'd1);
    cyc(1);
    check("halt_step_paused", 32'(controller_state), 32'd0);
    cyc(8);
    check("paused_ignores_halt", 32'(controller_state), 32'd0);
    halt_request = 0;
    press(0, 2'd1, "halt_rerun");
    cyc(8);
    halt_request = 1;
    cyc(1);
    check("halt_again", 32'(controller_state), 32'd3);
    halt_request = 0;
    press(0, 2'd0, "halted_run_to_paused");
    cyc(8);

    // Short glitch, then simultaneous run and step.
    do_reset();
    run_button = 1;
    cyc(3);
    run_button = 0;
    sum = 0;
    repeat (12) begin cyc(1); sum += int'(controller_state != 2'd0); end
    check("glitch_ignored", 32'(sum), 32'd0);
    run_button = 1;
    step_button = 1;
    cyc(7);
    check("run_wins", 32'(controller_state), 32'd1);
    run_button = 0;
    step_button = 0;
    cyc(8);

    // Reduce rate while the prescaler sits at 10.
    do_reset();
    rate_select = 4;
    press(0, 2'd1, "rate_entry");
    cyc(10);
    check("rate_no_tick_yet", 32'(cpu_clock_enable), 32'd0);
    rate_select = 2;
    cyc(1);
    check("rate_tick_now", 32'(cpu_clock_enable), 32'd1);
    sum = 0;
    repeat (3) begin cyc(1); sum += int'(cpu_clock_enable); end
    check("rate_gap", 32'(sum), 32'd0);
    cyc(1);
    check("rate_period4", 32'(cpu_clock_enable), 32'd1);

    // Reset mid-RUNNING, button held through reset.
    rate_select = 0;
    cyc(2);
    reset = 1;
    run_button = 1;
    cyc(1);
    check("rst_run_enable", 32'(cpu_clock_enable), 32'd0);
    check("rst_run_state", 32'(controller_state), 32'd0);
    cyc(10);
    check("rst_held_no_press", 32'(controller_state), 32'd0);
    reset = 0;
    cyc(6);
    check("rst_release_early", 32'(controller_state), 32'd0);
    cyc(1);
    check("rst_release_press", 32'(controller_state), 32'd1);
    run_button = 0;
    cyc(8);

    // Reset during STEP.
    do_reset();
    step_button = 1;
    cyc(7);
    check("rst_step_state", 32'(controller_state), 32'd2);
    reset = 1;
    cyc(1);
    check("rst_step_enable", 32'(cpu_clock_enable), 32'd0);
    do_reset();

    // Randomised traffic checked against the model every cycle.
    hold_r = 0;
    hold_s = 0;
    repeat (3000) begin
      if (hold_r == 0) begin run_button = ($urandom_range(0, 2) == 0); hold_r = $urandom_range(1, 12); end
      else hold_r--;
      if (hold_s == 0) begin step_button = ($urandom_range(0, 2) == 0); hold_s = $urandom_range(1, 12); end
      else hold_s--;
      if ($urandom_range(0, 29) == 0) halt_request = ~halt_request;
      if ($urandom_range(0, 39) == 0) rate_select = 5'($urandom_range(0, 4));
      reset = ($urandom_range(0, 249) == 0);
      cyc(1);
    end
    reset = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
